// File: rtl/bus_master_if.sv
// bus_master_if: master-side endpoint of the single-master bus handshake.
// Takes one burst command, requests the bus, issues cmd_len+1 single-cycle
// beats while granted, then releases the bus and pulses done.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, the grant wait
// is abandoned after TO_CYCLES cycles and timeout pulses. When it is not
// defined, the block waits for grant indefinitely and timeout stays 0.
module bus_master_if #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int LW        = 4,
    parameter int TO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wd_data,
    output logic          wd_pop,
    output logic          m_req,
    input  logic          m_grant,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_dout,
    input  logic [DW-1:0] m_din,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t        state;
    logic          wr_q;
    logic [AW-1:0] base_q;
    logic [LW-1:0] len_q;
    logic [LW:0]   beat_q;     // beats already issued; reaches 2^LW on max burst
    logic          rd_beat_q;  // a read beat is on the bus this cycle
    logic [AW-1:0] beat_addr;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TO_CYCLES > 0);
`endif

    // Address of the beat about to be issued; wraps modulo 2^AW.
    assign beat_addr = base_q + AW'(beat_q);

    // Write data is show-ahead, so the current head goes straight out on a
    // write beat and is popped at the end of that same cycle.
    assign wd_pop = m_wr;
    assign m_dout = m_wr ? wd_data : '0;

    // Burst sequencer: command latch, request/grant handshake, beat issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            m_req     <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            rd_beat_q <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            wr_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            // Bus is quiet and pulses are low unless a beat/event is issued below.
            m_wr      <= 1'b0;
            m_addr    <= '0;
            rd_beat_q <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q      <= cmd_wr;
                        base_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        beat_q    <= '0;
                        m_req     <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= REQ;
`ifdef BUS_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (m_grant) begin
                        m_addr    <= beat_addr;
                        m_wr      <= wr_q;
                        rd_beat_q <= ~wr_q;
                        beat_q    <= beat_q + 1'b1;
                        state     <= XFER;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (to_cnt == TW'(TO_CYCLES - 1)) begin
                        m_req     <= 1'b0;
                        timeout   <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt    <= to_cnt + 1'b1;
                    end
`endif
                end
                XFER: begin
                    if (beat_q > {1'b0, len_q}) begin
                        m_req <= 1'b0;
                        done  <= 1'b1;
                        state <= REL;
                    end else if (m_grant) begin
                        m_addr    <= beat_addr;
                        m_wr      <= wr_q;
                        rd_beat_q <= ~wr_q;
                        beat_q    <= beat_q + 1'b1;
                    end
                end
                REL: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is sampled at the end of each read beat cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_beat_q;
            if (rd_beat_q) rd_data <= m_din;
        end
    end

endmodule
